// File: rtl/lms_adapt_ctrl_if.sv
// Sample handshake between the sample source and lms_adapt_ctrl.
interface lms_adapt_ctrl_if;
  logic s_valid;
  logic s_ready;

  modport master (output s_valid, input s_ready);
  modport slave  (input s_valid, output s_ready);
endinterface

// File: rtl/lms_adapt_ctrl.sv
// LMS adaptation controller: paces the filter datapath one sample at a time,
// sequences FLUSH/TRAIN/TRACK/HOLD and tracks the windowed mean |error|.
// Optional divergence detection is compiled in with `define LMS_CTRL_DIVERGE_EN.
module lms_adapt_ctrl #(
  parameter int unsigned ERR_LAT   = 2,
  parameter int unsigned WIN_LOG2  = 4,
  parameter int unsigned FLUSH_LEN = 4,
  parameter int unsigned DIV_CNT   = 8,
  parameter int unsigned DIV_LIM   = 480
) (
  input  logic                clk,
  input  logic                rst,
  lms_adapt_ctrl_if.slave     smp,
  input  logic                start,
  input  logic                stop,
  input  logic                freeze,
  input  logic signed [9:0]   errr,
  input  logic        [9:0]   thr,
  output logic                samp_en,
  output logic                adapt_en,
  output logic                wclr,
  output logic        [2:0]   state,
  output logic                converged,
  output logic        [9:0]   err_mean,
  output logic                diverge
);

  localparam int unsigned ACC_W = 10 + WIN_LOG2;
  localparam int unsigned LAT_W = (ERR_LAT > 0) ? $clog2(ERR_LAT + 1) : 1;
  localparam int unsigned FL_W  = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam int unsigned WIN_W = (WIN_LOG2 > 0) ? WIN_LOG2 : 1;

  if (FLUSH_LEN == 0 || DIV_CNT == 0 || DIV_LIM > 1023) begin : g_cfg_err
    $error("lms_adapt_ctrl: invalid parameter set");
  end

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_TRAIN = 3'd2,
    ST_TRACK = 3'd3,
    ST_HOLD  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic               samp_en_q, samp_en_d;
  logic [FL_W-1:0]    flush_q, flush_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [9:0]         mean_q, mean_d;
  logic               conv_q, conv_d;

  logic               hs, cap, in_win, win_end, abort, div_hit;
  logic [9:0]         err_u, abs_e, mean_new;
  logic [ACC_W-1:0]   acc_sum;

  assign smp.s_ready = (state_q inside {ST_FLUSH, ST_TRAIN, ST_TRACK, ST_HOLD}) && !busy_q;
  assign hs          = smp.s_valid && smp.s_ready;
  assign cap         = busy_q && (lat_q == LAT_W'(ERR_LAT));
  assign in_win      = state_q inside {ST_TRAIN, ST_TRACK, ST_HOLD};
  assign win_end     = cap && in_win && ((WIN_LOG2 == 0) || (win_q == '1));
  assign abort       = (stop && state_q != ST_IDLE) ||
                       !(state_q inside {ST_IDLE, ST_FLUSH, ST_TRAIN, ST_TRACK, ST_HOLD});

  // |errr| as unsigned; -512 maps to 512 without overflow in 10 bits
  assign err_u    = errr;
  assign abs_e    = err_u[9] ? (~err_u + 10'd1) : err_u;
  assign acc_sum  = acc_q + ACC_W'(abs_e);
  assign mean_new = acc_sum[ACC_W-1:WIN_LOG2];

`ifdef LMS_CTRL_DIVERGE_EN
  localparam int unsigned DC_W = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
  logic            large;
  logic [DC_W-1:0] dcnt_q, dcnt_d;
  logic            div_q;

  assign large   = 32'(abs_e) >= DIV_LIM;
  assign div_hit = cap && in_win && large && !stop && (dcnt_q == DC_W'(DIV_CNT - 1));
  assign diverge = div_q;

  // Consecutive large-error counter and divergence pulse register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dcnt_q <= '0;
      div_q  <= 1'b0;
    end else begin
      dcnt_q <= dcnt_d;
      div_q  <= div_hit;
    end
  end

  // Next value of the consecutive large-error count
  always_comb begin
    dcnt_d = dcnt_q;
    if (cap && in_win) dcnt_d = large ? dcnt_q + 1'b1 : '0;
    if (div_hit || abort) dcnt_d = '0;
  end
`else
  assign div_hit = 1'b0;
  assign diverge = 1'b0;
`endif

  // Controller state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      lat_q     <= '0;
      samp_en_q <= 1'b0;
      flush_q   <= '0;
      win_q     <= '0;
      acc_q     <= '0;
      mean_q    <= '0;
      conv_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      lat_q     <= lat_d;
      samp_en_q <= samp_en_d;
      flush_q   <= flush_d;
      win_q     <= win_d;
      acc_q     <= acc_d;
      mean_q    <= mean_d;
      conv_q    <= conv_d;
    end
  end

  // Next-state, sample pacing, window accounting and state-decoded outputs
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    lat_d     = lat_q;
    samp_en_d = 1'b0;
    flush_d   = flush_q;
    win_d     = win_q;
    acc_d     = acc_q;
    mean_d    = mean_q;
    conv_d    = conv_q;
    adapt_en  = 1'b0;
    wclr      = 1'b0;

    if (hs) begin
      samp_en_d = 1'b1;
      busy_d    = 1'b1;
      lat_d     = '0;
    end else if (busy_q) begin
      if (cap) busy_d = 1'b0;
      else     lat_d  = lat_q + 1'b1;
    end

    if (cap && in_win) begin
      acc_d = acc_sum;
      win_d = win_q + 1'b1;
      if (win_end) begin
        mean_d = mean_new;
        acc_d  = '0;
        win_d  = '0;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        wclr = 1'b1;
        if (cap) begin
          flush_d = flush_q + 1'b1;
          if (flush_q == FL_W'(FLUSH_LEN - 1)) begin
            state_d = ST_TRAIN;
            flush_d = '0;
            acc_d   = '0;
            win_d   = '0;
          end
        end
      end
      ST_TRAIN: begin
        adapt_en = 1'b1;
        if (win_end && (mean_new < thr)) begin
          state_d = ST_TRACK;
          conv_d  = 1'b1;
        end
      end
      ST_TRACK: begin
        adapt_en = 1'b1;
        if (win_end && ({1'b0, mean_new} >= {thr, 1'b0})) begin
          state_d = ST_TRAIN;
          conv_d  = 1'b0;
        end else if (freeze) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!freeze) state_d = ST_TRACK;
      end
      default: state_d = ST_IDLE;
    endcase

    // Divergence restarts from FLUSH; stop/illegal codes outrank it below
    if (div_hit) begin
      state_d = ST_FLUSH;
      conv_d  = 1'b0;
      flush_d = '0;
      acc_d   = '0;
      win_d   = '0;
    end

    if (abort) begin
      state_d   = ST_IDLE;
      busy_d    = 1'b0;
      lat_d     = '0;
      samp_en_d = 1'b0;
      flush_d   = '0;
      win_d     = '0;
      acc_d     = '0;
      conv_d    = 1'b0;
    end
  end

  assign samp_en   = samp_en_q;
  assign state     = state_q;
  assign converged = conv_q;
  assign err_mean  = mean_q;

endmodule

// File: tb/tb_lms_adapt_ctrl.sv
// Directed bench for lms_adapt_ctrl at default parameters.
module tb_lms_adapt_ctrl;
  localparam int LAT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start, stop, freeze;
  logic signed [9:0] errr;
  logic        [9:0] thr;
  logic              samp_en, adapt_en, wclr, converged, diverge;
  logic        [2:0] state;
  logic        [9:0] err_mean;

  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  bit  div_seen = 1'b0;

  logic [1:0] se;
  int         sc, prev;

  lms_adapt_ctrl_if smp_if();

  lms_adapt_ctrl #(
    .ERR_LAT  (LAT),
    .WIN_LOG2 (4),
    .FLUSH_LEN(4),
    .DIV_CNT  (8),
    .DIV_LIM  (480)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .smp      (smp_if),
    .start    (start),
    .stop     (stop),
    .freeze   (freeze),
    .errr     (errr),
    .thr      (thr),
    .samp_en  (samp_en),
    .adapt_en (adapt_en),
    .wclr     (wclr),
    .state    (state),
    .converged(converged),
    .err_mean (err_mean),
    .diverge  (diverge)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (diverge) div_seen = 1'b1;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full sample: handshake, samp_en at t+1, return one cycle after capture
  task automatic do_sample(input logic signed [9:0] e, output logic [1:0] pulse, output int pc);
    int n;
    n = 0;
    pulse = 2'b00;
    pc = 0;
    errr = e;
    smp_if.s_valid = 1'b1;
    while (!smp_if.s_ready && n < 20) begin
      tick();
      n++;
    end
    if (!smp_if.s_ready) begin
      chk("s_ready_timeout", 0, 1);
      smp_if.s_valid = 1'b0;
      return;
    end
    tick();
    smp_if.s_valid = 1'b0;
    pulse[1] = samp_en;
    pc = cyc;
    tick();
    pulse[0] = samp_en;
    repeat (LAT) tick();
  endtask

  task automatic samples(input int cnt, input logic signed [9:0] e);
    logic [1:0] p;
    int c;
    for (int i = 0; i < cnt; i++) do_sample(e, p, c);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; freeze = 1'b0;
    errr = '0; thr = 10'd20; smp_if.s_valid = 1'b0;
    #12;
    chk("rst_state",    state, 0);
    chk("rst_s_ready",  smp_if.s_ready, 0);
    chk("rst_samp_en",  samp_en, 0);
    chk("rst_adapt_en", adapt_en, 0);
    chk("rst_wclr",     wclr, 0);
    chk("rst_conv",     converged, 0);
    chk("rst_err_mean", err_mean, 0);
    chk("rst_diverge",  diverge, 0);
    @(negedge clk); rst = 1'b1;
    tick(); tick();
    chk("idle_state", state, 0);
    chk("idle_s_ready", smp_if.s_ready, 0);

    start = 1'b1; tick(); start = 1'b0;
    chk("flush_state", state, 1);
    chk("flush_wclr", wclr, 1);
    chk("flush_adapt", adapt_en, 0);
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      do_sample(10'sd0, se, sc);
      chk("flush_samp_en", int'(se), 2);
      if (i > 0) chk("flush_period", sc - prev, 4);
      prev = sc;
      if (i < 3) chk("flush_hold", state, 1);
    end
    chk("train_state", state, 2);
    chk("train_wclr", wclr, 0);
    chk("train_adapt", adapt_en, 1);

    samples(15, 10'sd10);
    chk("win15_state", state, 2);
    chk("win15_mean", err_mean, 0);
    samples(1, 10'sd10);
    chk("conv_mean", err_mean, 10);
    chk("conv_state", state, 3);
    chk("conv_flag", converged, 1);

    start = 1'b1; tick(); start = 1'b0;
    chk("start_ignored", state, 3);

    freeze = 1'b1; tick();
    chk("hold_state", state, 4);
    chk("hold_adapt", adapt_en, 0);
    chk("hold_conv", converged, 1);
    freeze = 1'b0; tick();
    chk("unfreeze_state", state, 3);

    samples(16, -10'sd40);
    chk("reconv_mean", err_mean, 40);
    chk("reconv_state", state, 2);
    chk("reconv_conv", converged, 0);

    samples(16, 10'sd10);
    chk("track2_state", state, 3);

    div_seen = 1'b0;
`ifdef LMS_CTRL_DIVERGE_EN
    samples(7, -10'sd512);
    chk("div7_state", state, 3);
    chk("div7_seen", int'(div_seen), 0);
    samples(1, -10'sd512);
    chk("div_pulse", diverge, 1);
    chk("div_state", state, 1);
    chk("div_conv", converged, 0);
    tick();
    chk("div_pulse_end", diverge, 0);
    samples(4, 10'sd0);
    chk("div_retrain", state, 2);
    div_seen = 1'b0;
    for (int r = 0; r < 2; r++) begin
      samples(7, -10'sd512);
      samples(1, 10'sd0);
    end
    chk("divrst_seen", int'(div_seen), 0);
    chk("divrst_mean", err_mean, 448);
    chk("divrst_state", state, 2);
`else
    samples(15, -10'sd512);
    chk("big15_state", state, 3);
    samples(1, -10'sd512);
    chk("big_mean", err_mean, 512);
    chk("big_state", state, 2);
    chk("big_no_div", int'(div_seen), 0);
`endif

    samples(16, 10'sd10);
    chk("track3_state", state, 3);
    chk("track3_mean", err_mean, 10);

    smp_if.s_valid = 1'b1;
    chk("stop_ready", smp_if.s_ready, 1);
    tick();
    smp_if.s_valid = 1'b0;
    chk("stop_samp_en", samp_en, 1);
    tick();
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_state", state, 0);
    chk("stop_ready0", smp_if.s_ready, 0);
    chk("stop_conv", converged, 0);
    chk("stop_mean", err_mean, 10);
    repeat (3) tick();
    chk("stop_mean_kept", err_mean, 10);

    start = 1'b1; stop = 1'b1; tick();
    chk("start_stop_idle", state, 0);
    stop = 1'b0; tick(); start = 1'b0;
    chk("restart_state", state, 1);
    samples(4, 10'sd0);
    samples(16, 10'sd30);
    chk("fresh_mean", err_mean, 30);
    chk("fresh_state", state, 2);

    smp_if.s_valid = 1'b1;
    tick();
    #3; rst = 1'b0; #1;
    chk("async_state", state, 0);
    chk("async_adapt", adapt_en, 0);
    chk("async_mean", err_mean, 0);
    @(negedge clk); rst = 1'b1;
    repeat (6) tick();
    chk("post_rst_state", state, 0);
    chk("post_rst_samp_en", samp_en, 0);
    chk("post_rst_ready", smp_if.s_ready, 0);
    smp_if.s_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lms_adapt_ctrl.md
LMS_ADAPT_CTRL -- requirements
Module: lms_adapt_ctrl

Interface
REQ-001 Parameter ERR_LAT, default 2: cycles from samp_en pulse to errr valid at the filter output.
REQ-002 Parameter WIN_LOG2, default 4: convergence window is 2^WIN_LOG2 captured errors.
REQ-003 Parameter FLUSH_LEN, default 4: samples accepted in FLUSH, equal to the filter tap count.
REQ-004 Parameter DIV_CNT, default 8: consecutive large errors that trigger divergence.
REQ-005 Parameter DIV_LIM, default 480: |errr| at or above this value counts as a large error.
REQ-006 Ports, one per line (name, direction, width, meaning):
  clk  in  1  single clock, rising edge.
  rst  in  1  asynchronous, active-low reset.
  start  in  1  begin adaptation; honoured only in IDLE.
  stop  in  1  abort to IDLE from any state.
  freeze  in  1  level; holds weights while in TRACK.
  s_valid  in  1  input sample valid.
  s_ready  out  1  controller can accept a sample.
  errr  in  10 signed  filter error, din minus filt_out.
  thr  in  10 unsigned  convergence threshold on the window mean |errr|.
  samp_en  out  1  one-cycle pulse that advances the filter datapath by one sample.
  adapt_en  out  1  weight-update enable.
  wclr  out  1  weight clear.
  state  out  3  FSM state code.
  converged  out  1  adaptation converged.
  err_mean  out  10  last completed window mean of |errr|.
  diverge  out  1  one-cycle divergence pulse.

Function
REQ-007 State codes: IDLE=0, FLUSH=1, TRAIN=2, TRACK=3, HOLD=4; codes 5-7 return to IDLE on the next edge.
REQ-008 Handshake: a sample transfers when s_valid=1 and s_ready=1 in the same cycle (cycle t); s_ready=0 in IDLE.
REQ-009 samp_en pulses at t+1; errr is captured at t+1+ERR_LAT; s_ready is low from t+1 through the capture cycle and high again the cycle after.
REQ-010 Consequence: the minimum sample period is ERR_LAT+2 cycles (4 at the default).
REQ-011 IDLE: wclr=0, adapt_en=0; start=1 -> FLUSH.
REQ-012 FLUSH: wclr=1, adapt_en=0; after the FLUSH_LEN-th capture -> TRAIN, with the window accumulator cleared.
REQ-013 TRAIN, TRACK and HOLD: each capture adds |errr| to the accumulator; |-512| = 512; accumulator width is 10+WIN_LOG2 bits with no overflow.
REQ-014 At each window end: err_mean = acc >> WIN_LOG2, then acc and the window count clear.
REQ-015 TRAIN: adapt_en=1; at a window end with err_mean < thr -> TRACK and converged=1; otherwise stay in TRAIN.
REQ-016 TRACK: adapt_en=1; at a window end with err_mean >= 2*thr (11-bit compare) -> TRAIN and converged=0.
REQ-017 TRACK with freeze=1 -> HOLD; the freeze test is evaluated after the window compare.
REQ-018 HOLD: adapt_en=0; samples and windows continue; err_mean updates; converged holds.
REQ-019 HOLD with freeze=0 -> TRACK; any window compare in HOLD is ignored.
REQ-020 stop=1 in any non-IDLE state -> IDLE at the next edge; it abandons a pending capture and clears acc, counters and converged; stop has priority over every other transition.
REQ-021 start outside IDLE is ignored.
REQ-022 start and stop asserted together in IDLE -> stay in IDLE.
REQ-023 A capture that coincides with a state change is accounted in the old state.

Reset
REQ-024 rst low forces state=IDLE, s_ready=0, samp_en=0, adapt_en=0, wclr=0, converged=0, err_mean=0, diverge=0, with all counters and the accumulator cleared, immediately and independent of clk.
REQ-025 Reset released mid-operation resumes in IDLE only; no pending capture survives.

Configuration
REQ-026 Macro LMS_CTRL_DIVERGE_EN defined: in TRAIN, TRACK or HOLD, DIV_CNT consecutive captures with |errr| >= DIV_LIM cause a one-cycle diverge pulse, converged=0, and -> FLUSH.
REQ-027 With LMS_CTRL_DIVERGE_EN defined: any capture below DIV_LIM resets the consecutive count.
REQ-028 Macro LMS_CTRL_DIVERGE_EN undefined: diverge is tied 0 and no divergence logic is present; all other behaviour is identical.

Verification
REQ-029 Reset/start: rst low, then high; start pulse; s_valid held 1 -> state 0->1; wclr=1; samp_en pulses every 4 cycles; after 4 captures state=2 and wclr=0.
REQ-030 Convergence: thr=20; errr=10 for 16 samples in TRAIN -> err_mean=10, state=3, converged=1.
REQ-031 Reconvergence and freeze: in TRACK, thr=20, errr=-40 for 16 samples -> err_mean=40, state=2, converged=0; separately, freeze=1 in TRACK -> state=4, adapt_en=0; freeze=0 -> state=3.
REQ-032 Stop mid-capture: stop asserted 2 cycles after a handshake -> state=0 next cycle, s_ready=0, no capture, converged=0, err_mean unchanged.
REQ-033 Divergence with LMS_CTRL_DIVERGE_EN: errr=-512 for 8 captures in TRACK -> diverge pulse, state=1. Without the macro, the same stimulus -> diverge stays 0 and state=2 at the window end.
REQ-034 Boundary: errr=-512 for 16 captures -> err_mean=512, no accumulator overflow.
